// File: rtl/laser_frame_pkg.sv
// Shared constants, FSM state encoding and helpers for the laser frame packer.
package laser_frame_pkg;

    localparam logic [15:0] HDR_MAGIC       = 16'hA5A5;
    localparam logic [15:0] TRL_MAGIC_OK    = 16'h5A5A;
    localparam logic [15:0] TRL_MAGIC_SHORT = 16'h5A5B;

    // Header, info and trailer words that surround the data words of a frame.
    localparam int FRAME_OVH = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HEADER  = 3'd1,
        ST_INFO    = 3'd2,
        ST_DATA    = 3'd3,
        ST_TRAILER = 3'd4,
        ST_DROP    = 3'd5
    } state_e;

    // 16-bit increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/laser_sample_skid.sv
// Small synchronous FIFO decoupling sample arrival from frame word writes.
// Handshake: push_i is accepted when the buffer is not full or a pop happens
// in the same cycle; pop_i is honoured only when the buffer is non-empty and
// pop_data_o shows the head entry combinationally. flush_i empties the buffer
// and wins over push/pop in the same cycle.
module laser_sample_skid #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output logic [W-1:0] pop_data_o,
    output logic         empty_o,
    output logic         full_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == (AW+1)'(DEPTH));
    assign do_pop     = pop_i && !empty_o;
    assign do_push    = push_i && (!full_o || do_pop);
    assign pop_data_o = mem_q[rd_ptr_q];

    // Storage array; contents are meaningless while count is zero, so no reset.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/laser_frame_packer.sv
// Frames one motor revolution of distance/intensity samples into the laser
// FIFO as header, info, data words and a checksum trailer. A frame is only
// started when the whole frame fits in the FIFO; otherwise it is dropped.
module laser_frame_packer
    import laser_frame_pkg::*;
#(
    parameter int SAMPLES_PER_FRAME = 1800,
    parameter int FIFO_DEPTH        = 2048,
    parameter int USEDW_W           = 11,
    parameter int SKID_DEPTH        = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_enable,
    input  logic               scan_start,
    input  logic [15:0]        motor_speed,
    input  logic               sample_valid,
    input  logic [15:0]        sample_distance,
    input  logic [15:0]        sample_intensity,
    output logic               fifo_wrreq,
    output logic [31:0]        fifo_wrdata,
    input  logic [USEDW_W-1:0] fifo_usedw,
    input  logic               fifo_full,
    output logic [15:0]        frame_cnt,
    output logic [15:0]        drop_cnt,
    output logic [15:0]        short_cnt,
    output logic               sample_ovf,
    output logic               busy
);

    localparam logic [15:0] SPF16 = 16'(SAMPLES_PER_FRAME);

    state_e      state_q;
    logic        busy_q;
    logic        wrreq_q;
    logic [31:0] wrdata_q;
    logic [15:0] frame_cnt_q;
    logic [15:0] drop_cnt_q;
    logic [15:0] short_cnt_q;
    logic        ovf_q;
    logic [15:0] speed_q;
    logic [15:0] pend_speed_q;
    logic [15:0] checksum_q;
    logic [15:0] idx_q;
    logic        short_q;
    logic        pending_q;

    logic        in_frame;
    logic [31:0] need_words;
    logic        space_ok;
    logic        launch;
    logic        writing;
    logic        skid_push;
    logic        skid_pop;
    logic        skid_flush;
    logic        skid_lost;
    logic        skid_empty;
    logic        skid_full;
    logic [31:0] skid_data;

    assign in_frame   = (state_q == ST_HEADER) || (state_q == ST_INFO) ||
                        (state_q == ST_DATA)   || (state_q == ST_TRAILER);
    assign need_words = 32'(fifo_usedw) + 32'(SAMPLES_PER_FRAME) + 32'(FRAME_OVH);
    assign space_ok   = !fifo_full && (need_words <= 32'(FIFO_DEPTH - 1));

    // A frame start is evaluated from IDLE/DROP on scan_start, or at the end of
    // a trailer when a start arrived while the previous frame was in flight.
    assign launch = cfg_enable &&
                    ((((state_q == ST_IDLE) || (state_q == ST_DROP)) && scan_start) ||
                     ((state_q == ST_TRAILER) && (pending_q || scan_start)));

    // Samples past the end of a full frame have nowhere to go and are dropped.
    assign skid_push  = sample_valid && in_frame && (idx_q != SPF16);
    assign skid_pop   = (state_q == ST_DATA) && !short_q && !scan_start && !skid_empty;
    // Samples buffered behind an early scan_start belong to the next frame, so
    // the flush is skipped when launching straight out of a trailer.
    assign skid_flush = launch && space_ok && (state_q != ST_TRAILER);
    assign skid_lost  = skid_push && skid_full && !skid_pop;
    assign writing    = (state_q == ST_HEADER) || (state_q == ST_INFO) ||
                        (state_q == ST_TRAILER) || skid_pop;

    laser_sample_skid #(
        .DEPTH (SKID_DEPTH),
        .W     (32)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (skid_push),
        .push_data_i ({sample_distance, sample_intensity}),
        .pop_i       (skid_pop),
        .flush_i     (skid_flush),
        .pop_data_o  (skid_data),
        .empty_o     (skid_empty),
        .full_o      (skid_full)
    );

    // Frame FSM with registered FIFO write port, counters and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            wrreq_q      <= 1'b0;
            wrdata_q     <= '0;
            frame_cnt_q  <= '0;
            drop_cnt_q   <= '0;
            short_cnt_q  <= '0;
            ovf_q        <= 1'b0;
            speed_q      <= '0;
            pend_speed_q <= '0;
            checksum_q   <= '0;
            idx_q        <= '0;
            short_q      <= 1'b0;
            pending_q    <= 1'b0;
        end else begin
            wrreq_q <= 1'b0;
            if (skid_lost || (writing && fifo_full)) ovf_q <= 1'b1;

            case (state_q)
                ST_HEADER, ST_INFO: begin
                    wrreq_q <= 1'b1;
                    if (state_q == ST_HEADER) begin
                        wrdata_q    <= {HDR_MAGIC, frame_cnt_q};
                        frame_cnt_q <= frame_cnt_q + 16'd1;
                        state_q     <= ST_INFO;
                    end else begin
                        wrdata_q <= {SPF16, speed_q};
                        state_q  <= ST_DATA;
                    end
                    if (scan_start) begin
                        pending_q    <= 1'b1;
                        pend_speed_q <= motor_speed;
                        if (!short_q) begin
                            short_q     <= 1'b1;
                            short_cnt_q <= sat_inc16(short_cnt_q);
                        end
                    end
                end
                ST_DATA: begin
                    if (scan_start || short_q) begin
                        state_q <= ST_TRAILER;
                        if (scan_start) begin
                            pending_q    <= 1'b1;
                            pend_speed_q <= motor_speed;
                            if (!short_q) begin
                                short_q     <= 1'b1;
                                short_cnt_q <= sat_inc16(short_cnt_q);
                            end
                        end
                    end else if (skid_pop) begin
                        wrreq_q    <= 1'b1;
                        wrdata_q   <= skid_data;
                        checksum_q <= checksum_q + skid_data[31:16] + skid_data[15:0];
                        idx_q      <= idx_q + 16'd1;
                        if (idx_q + 16'd1 == SPF16) state_q <= ST_TRAILER;
                    end
                end
                ST_TRAILER: begin
                    wrreq_q   <= 1'b1;
                    wrdata_q  <= {short_q ? TRL_MAGIC_SHORT : TRL_MAGIC_OK, checksum_q};
                    state_q   <= ST_IDLE;
                    busy_q    <= 1'b0;
                    short_q   <= 1'b0;
                    pending_q <= 1'b0;
                end
                ST_DROP: begin
                    if (scan_start && !cfg_enable) state_q <= ST_IDLE;
                end
                default: begin
                end
            endcase

            // Space check overrides the state chosen above when a frame start is due.
            if (launch) begin
                pending_q <= 1'b0;
                if (space_ok) begin
                    state_q    <= ST_HEADER;
                    busy_q     <= 1'b1;
                    speed_q    <= ((state_q == ST_TRAILER) && pending_q) ? pend_speed_q : motor_speed;
                    checksum_q <= '0;
                    idx_q      <= '0;
                    short_q    <= 1'b0;
                end else begin
                    drop_cnt_q <= sat_inc16(drop_cnt_q);
                    state_q    <= ST_DROP;
                    busy_q     <= 1'b0;
                end
            end
        end
    end

    assign fifo_wrreq  = wrreq_q;
    assign fifo_wrdata = wrdata_q;
    assign frame_cnt   = frame_cnt_q;
    assign drop_cnt    = drop_cnt_q;
    assign short_cnt   = short_cnt_q;
    assign sample_ovf  = ovf_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_laser_frame_packer.sv
// Directed bench for laser_frame_packer with a 4-sample frame.
module tb_laser_frame_packer;

    localparam int SPF = 4;

    logic        clk;
    logic        rst_n;
    logic        cfg_enable;
    logic        scan_start;
    logic [15:0] motor_speed;
    logic        sample_valid;
    logic [15:0] sample_distance;
    logic [15:0] sample_intensity;
    logic        fifo_wrreq;
    logic [31:0] fifo_wrdata;
    logic [10:0] fifo_usedw;
    logic        fifo_full;
    logic [15:0] frame_cnt;
    logic [15:0] drop_cnt;
    logic [15:0] short_cnt;
    logic        sample_ovf;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [31:0] wr_q[$];
    int          wr_cyc[$];
    logic [31:0] exp_q[$];

    laser_frame_packer #(
        .SAMPLES_PER_FRAME (SPF),
        .FIFO_DEPTH        (2048),
        .USEDW_W           (11),
        .SKID_DEPTH        (4)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cfg_enable       (cfg_enable),
        .scan_start       (scan_start),
        .motor_speed      (motor_speed),
        .sample_valid     (sample_valid),
        .sample_distance  (sample_distance),
        .sample_intensity (sample_intensity),
        .fifo_wrreq       (fifo_wrreq),
        .fifo_wrdata      (fifo_wrdata),
        .fifo_usedw       (fifo_usedw),
        .fifo_full        (fifo_full),
        .frame_cnt        (frame_cnt),
        .drop_cnt         (drop_cnt),
        .short_cnt        (short_cnt),
        .sample_ovf       (sample_ovf),
        .busy             (busy)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (fifo_wrreq) begin
            wr_q.push_back(fifo_wrdata);
            wr_cyc.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    // Driver tasks
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [15:0] speed);
        scan_start  = 1'b1;
        motor_speed = speed;
        step(1);
        scan_start  = 1'b0;
    endtask

    task automatic send_sample(input logic [15:0] d, input logic [15:0] i, input int gap);
        sample_valid     = 1'b1;
        sample_distance  = d;
        sample_intensity = i;
        step(1);
        sample_valid     = 1'b0;
        step(gap - 1);
    endtask

    task automatic clear_log();
        wr_q.delete();
        wr_cyc.delete();
        exp_q.delete();
    endtask

    // Tests
    task automatic test_reset();
        n_checks++;
        if ({fifo_wrreq, fifo_wrdata, busy, sample_ovf} !== 35'd0)
            $display("FAIL reset_outputs got %h want 0", {fifo_wrreq, fifo_wrdata, busy, sample_ovf});
        else n_pass++;
        n_checks++;
        if ({frame_cnt, drop_cnt, short_cnt} !== 48'd0)
            $display("FAIL reset_counters got %h want 0", {frame_cnt, drop_cnt, short_cnt});
        else n_pass++;
    endtask

    task automatic test_basic_frame();
        clear_log();
        exp_q = '{32'hA5A50000, 32'h00041234, 32'h00010002, 32'h00030004,
                  32'h00050006, 32'h00070008, 32'h5A5A0024};
        pulse_start(16'h1234);
        send_sample(16'd1, 16'd2, 3);
        send_sample(16'd3, 16'd4, 3);
        send_sample(16'd5, 16'd6, 3);
        send_sample(16'd7, 16'd8, 3);
        step(10);
        n_checks++;
        if (wr_q.size() !== exp_q.size()) $display("FAIL basic_count got %0d want %0d", wr_q.size(), exp_q.size());
        else n_pass++;
        for (int k = 0; k < exp_q.size(); k++) begin
            logic [31:0] got;
            got = (k < wr_q.size()) ? wr_q[k] : 32'hxxxxxxxx;
            n_checks++;
            if (got !== exp_q[k]) $display("FAIL basic_word%0d got %h want %h", k, got, exp_q[k]);
            else n_pass++;
        end
        n_checks++;
        if (frame_cnt !== 16'd1) $display("FAIL basic_frame_cnt got %0d want 1", frame_cnt);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL basic_busy got %b want 0", busy);
        else n_pass++;
    endtask

    task automatic test_drop();
        clear_log();
        fifo_usedw = 11'd2044;
        pulse_start(16'h0001);
        send_sample(16'hDEAD, 16'hBEEF, 3);
        send_sample(16'hDEAD, 16'hBEEF, 3);
        step(5);
        n_checks++;
        if (wr_q.size() !== 0) $display("FAIL drop_nowrites got %0d want 0", wr_q.size());
        else n_pass++;
        n_checks++;
        if (drop_cnt !== 16'd1) $display("FAIL drop_cnt got %0d want 1", drop_cnt);
        else n_pass++;
        n_checks++;
        if (frame_cnt !== 16'd1 || busy !== 1'b0)
            $display("FAIL drop_state got frame_cnt=%0d busy=%b want 1/0", frame_cnt, busy);
        else n_pass++;
        // Next start out of DROP with room: only the new samples appear
        fifo_usedw = 11'd0;
        exp_q = '{32'hA5A50001, 32'h00040777, 32'h00100020, 32'h00300040,
                  32'h00500060, 32'h00700080, 32'h5A5A0240};
        pulse_start(16'h0777);
        send_sample(16'h10, 16'h20, 3);
        send_sample(16'h30, 16'h40, 3);
        send_sample(16'h50, 16'h60, 3);
        send_sample(16'h70, 16'h80, 3);
        step(10);
        n_checks++;
        if (wr_q.size() !== exp_q.size()) $display("FAIL afterdrop_count got %0d want %0d", wr_q.size(), exp_q.size());
        else n_pass++;
        for (int k = 0; k < exp_q.size(); k++) begin
            logic [31:0] got;
            got = (k < wr_q.size()) ? wr_q[k] : 32'hxxxxxxxx;
            n_checks++;
            if (got !== exp_q[k]) $display("FAIL afterdrop_word%0d got %h want %h", k, got, exp_q[k]);
            else n_pass++;
        end
    endtask

    task automatic test_space_boundary();
        clear_log();
        fifo_usedw = 11'd2041;   // 2041 + 4 + 3 = 2048 > 2047
        pulse_start(16'h0000);
        step(3);
        n_checks++;
        if (drop_cnt !== 16'd2 || wr_q.size() !== 0)
            $display("FAIL bound_2041 got drop=%0d writes=%0d want 2/0", drop_cnt, wr_q.size());
        else n_pass++;
        fifo_usedw = 11'd2040;   // 2040 + 4 + 3 = 2047, just fits
        exp_q = '{32'hA5A50002, 32'h00040000, 32'h00010000, 32'h00020000,
                  32'h00030000, 32'h00040000, 32'h5A5A000A};
        pulse_start(16'h0000);
        send_sample(16'd1, 16'd0, 3);
        send_sample(16'd2, 16'd0, 3);
        send_sample(16'd3, 16'd0, 3);
        send_sample(16'd4, 16'd0, 3);
        step(10);
        n_checks++;
        if (wr_q.size() !== exp_q.size()) $display("FAIL bound_2040_count got %0d want %0d", wr_q.size(), exp_q.size());
        else n_pass++;
        for (int k = 0; k < exp_q.size(); k++) begin
            logic [31:0] got;
            got = (k < wr_q.size()) ? wr_q[k] : 32'hxxxxxxxx;
            n_checks++;
            if (got !== exp_q[k]) $display("FAIL bound_2040_word%0d got %h want %h", k, got, exp_q[k]);
            else n_pass++;
        end
        // fifo_full alone forces a drop even with usedw at zero
        clear_log();
        fifo_usedw = 11'd0;
        fifo_full  = 1'b1;
        pulse_start(16'h0000);
        step(3);
        fifo_full = 1'b0;
        n_checks++;
        if (drop_cnt !== 16'd3 || wr_q.size() !== 0)
            $display("FAIL full_drop got drop=%0d writes=%0d want 3/0", drop_cnt, wr_q.size());
        else n_pass++;
    endtask

    task automatic test_short_frame();
        clear_log();
        exp_q = '{32'hA5A50003, 32'h00040100, 32'h00010001, 32'h00020002, 32'h5A5B0006,
                  32'hA5A50004, 32'h000400AB, 32'h00030003, 32'h00040004,
                  32'h00050005, 32'h00060006, 32'h5A5A0024};
        pulse_start(16'h0100);
        send_sample(16'd1, 16'd1, 3);
        send_sample(16'd2, 16'd2, 3);
        pulse_start(16'h00AB);
        send_sample(16'd3, 16'd3, 3);
        send_sample(16'd4, 16'd4, 3);
        send_sample(16'd5, 16'd5, 3);
        send_sample(16'd6, 16'd6, 3);
        step(10);
        n_checks++;
        if (wr_q.size() !== exp_q.size()) $display("FAIL short_count got %0d want %0d", wr_q.size(), exp_q.size());
        else n_pass++;
        for (int k = 0; k < exp_q.size(); k++) begin
            logic [31:0] got;
            got = (k < wr_q.size()) ? wr_q[k] : 32'hxxxxxxxx;
            n_checks++;
            if (got !== exp_q[k]) $display("FAIL short_word%0d got %h want %h", k, got, exp_q[k]);
            else n_pass++;
        end
        n_checks++;
        if (wr_cyc.size() < 6) $display("FAIL short_gap got %0d writes want >=6", wr_cyc.size());
        else if (wr_cyc[5] !== wr_cyc[4] + 1)
            $display("FAIL short_gap got header cycle %0d want %0d", wr_cyc[5], wr_cyc[4] + 1);
        else n_pass++;
        n_checks++;
        if (short_cnt !== 16'd1 || frame_cnt !== 16'd5)
            $display("FAIL short_counters got short=%0d frames=%0d want 1/5", short_cnt, frame_cnt);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        clear_log();
        exp_q = '{32'hA5A50005, 32'h00040042, 32'h01000001, 32'h02000002,
                  32'h03000003, 32'h04000004, 32'h5A5A0A0A};
        pulse_start(16'h0042);
        send_sample(16'h0100, 16'h0001, 2);
        send_sample(16'h0200, 16'h0002, 2);
        send_sample(16'h0300, 16'h0003, 2);
        send_sample(16'h0400, 16'h0004, 2);
        step(10);
        n_checks++;
        if (wr_q.size() !== exp_q.size()) $display("FAIL b2b_count got %0d want %0d", wr_q.size(), exp_q.size());
        else n_pass++;
        for (int k = 0; k < exp_q.size(); k++) begin
            logic [31:0] got;
            got = (k < wr_q.size()) ? wr_q[k] : 32'hxxxxxxxx;
            n_checks++;
            if (got !== exp_q[k]) $display("FAIL b2b_word%0d got %h want %h", k, got, exp_q[k]);
            else n_pass++;
        end
        n_checks++;
        if (sample_ovf !== 1'b0) $display("FAIL b2b_ovf got %b want 0", sample_ovf);
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        clear_log();
        pulse_start(16'h0999);
        send_sample(16'd9, 16'd9, 3);
        rst_n = 1'b0;
        step(1);
        n_checks++;
        if ({fifo_wrreq, fifo_wrdata, busy, sample_ovf} !== 35'd0)
            $display("FAIL midrst_outputs got %h want 0", {fifo_wrreq, fifo_wrdata, busy, sample_ovf});
        else n_pass++;
        n_checks++;
        if ({frame_cnt, drop_cnt, short_cnt} !== 48'd0)
            $display("FAIL midrst_counters got %h want 0", {frame_cnt, drop_cnt, short_cnt});
        else n_pass++;
        step(1);
        rst_n = 1'b1;
        step(1);
        clear_log();
        exp_q = '{32'hA5A50000, 32'h00040555, 32'h00010001, 32'h00020002,
                  32'h00030003, 32'h00040004, 32'h5A5A0014};
        pulse_start(16'h0555);
        send_sample(16'd1, 16'd1, 3);
        send_sample(16'd2, 16'd2, 3);
        send_sample(16'd3, 16'd3, 3);
        send_sample(16'd4, 16'd4, 3);
        step(10);
        n_checks++;
        if (wr_q.size() !== exp_q.size()) $display("FAIL postrst_count got %0d want %0d", wr_q.size(), exp_q.size());
        else n_pass++;
        for (int k = 0; k < exp_q.size(); k++) begin
            logic [31:0] got;
            got = (k < wr_q.size()) ? wr_q[k] : 32'hxxxxxxxx;
            n_checks++;
            if (got !== exp_q[k]) $display("FAIL postrst_word%0d got %h want %h", k, got, exp_q[k]);
            else n_pass++;
        end
    endtask

    task automatic test_cfg_disable();
        clear_log();
        cfg_enable = 1'b0;
        pulse_start(16'h0123);
        send_sample(16'd1, 16'd1, 3);
        send_sample(16'd2, 16'd2, 3);
        fifo_usedw = 11'd2044;
        pulse_start(16'h0123);
        step(5);
        fifo_usedw = 11'd0;
        n_checks++;
        if (wr_q.size() !== 0) $display("FAIL cfgoff_writes got %0d want 0", wr_q.size());
        else n_pass++;
        n_checks++;
        if (frame_cnt !== 16'd1 || drop_cnt !== 16'd0 || short_cnt !== 16'd0 || busy !== 1'b0)
            $display("FAIL cfgoff_counters got f=%0d d=%0d s=%0d busy=%b want 1/0/0/0",
                     frame_cnt, drop_cnt, short_cnt, busy);
        else n_pass++;
        cfg_enable = 1'b1;
    endtask

    // Sequencer
    initial begin
        rst_n            = 1'b0;
        cfg_enable       = 1'b1;
        scan_start       = 1'b0;
        motor_speed      = '0;
        sample_valid     = 1'b0;
        sample_distance  = '0;
        sample_intensity = '0;
        fifo_usedw       = '0;
        fifo_full        = 1'b0;
        step(3);
        rst_n = 1'b1;
        step(2);

        test_reset();
        test_basic_frame();
        test_drop();
        test_space_boundary();
        test_short_frame();
        test_back_to_back();
        test_reset_mid_frame();
        test_cfg_disable();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
